// File: rtl/boa_peri_timer_if.sv
// Peripheral sub-bus: single-cycle register access with combinational ready/rdata.
// The MEM side is the peripheral; CPU is the requester.
interface boa_mem_bus #(
  parameter int alen = 12
) ();
  logic            re;
  logic [3:0]      we;
  logic [alen-1:0] addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_peri_timer.sv
// Multi-channel down-counting timer with a shared prescaler, periodic/one-shot
// modes, sticky pending flags and registered maskable interrupts.
module boa_peri_timer #(
  parameter int addr      = 'h300,
  parameter int channels  = 4,
  parameter int width     = 32,
  parameter int pre_width = 16
) (
  input  logic                clk,
  input  logic                rst,
  boa_mem_bus.MEM             bus,
  output logic [channels-1:0] irq
);

  localparam logic [3:0]           BASE_HI  = 4'(addr >> 8);
  localparam logic [5:0]           IDX_PRE  = 6'h3C;
  localparam logic [5:0]           IDX_PEND = 6'h3D;
  localparam logic [pre_width-1:0] PRE_ONE  = pre_width'(1);
  localparam logic [width-1:0]     CNT_ONE  = width'(1);

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // ---------------- bus decode ----------------
  logic        hit;
  logic        acc;
  logic        wr;
  logic [5:0]  off;
  logic        is_ch;
  logic [2:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic [31:0] byte_mask;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign off       = bus.addr[7:2];
  assign hit       = (bus.addr[11:8] == BASE_HI);
  assign acc       = hit & (bus.re | (|bus.we));
  assign wr        = hit & (|bus.we);
  assign is_ch     = ~off[5];
  assign sel_ch    = off[4:2];
  assign sel_reg   = off[1:0];
  assign byte_mask = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
  assign unused_bits = ^bus.addr[1:0];

  // ---------------- prescaler ----------------
  logic [pre_width-1:0] prescale_q, prescale_d;
  logic [pre_width-1:0] pre_cnt_q, pre_cnt_d;
  logic                 prescale_wr;
  logic                 tick;
  logic [31:0]          prescale_m;

  assign prescale_wr = wr & (off == IDX_PRE);
  assign prescale_m  = merge(32'(prescale_q), bus.wdata, byte_mask);

  // A PRESCALE write restarts the count and suppresses the tick of that cycle.
  always_comb begin
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q + PRE_ONE;
    tick       = 1'b0;
    if (prescale_wr) begin
      prescale_d = prescale_m[pre_width-1:0];
      pre_cnt_d  = '0;
    end else if (pre_cnt_q == prescale_q) begin
      tick      = 1'b1;
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  // ---------------- channels ----------------
  logic [31:0]         rd_ctrl [channels];
  logic [31:0]         rd_cnt  [channels];
  logic [31:0]         rd_rld  [channels];
  logic [channels-1:0] pend_vec;

  for (genvar gi = 0; gi < channels; gi++) begin : g_ch
    logic             en_q, en_d;
    logic             os_q, os_d;
    logic             ie_q, ie_d;
    logic             pend_q, pend_d;
    logic             irq_q, irq_d;
    logic [width-1:0] cnt_q, cnt_d;
    logic [width-1:0] rld_q, rld_d;
    logic             sel;
    logic             ctrl_wr, cnt_wr, rld_wr, stat_wr;
    logic             expire;
    logic [31:0]      ctrl_m, cnt_m, rld_m;

    assign sel     = wr & is_ch & (sel_ch == 3'(gi));
    assign ctrl_wr = sel & (sel_reg == 2'd0);
    assign cnt_wr  = sel & (sel_reg == 2'd1);
    assign rld_wr  = sel & (sel_reg == 2'd2);
    assign stat_wr = sel & (sel_reg == 2'd3);

    // A COUNT write in a tick cycle overrides both decrement and expiry;
    // a new expiry beats a simultaneous W1C.
    always_comb begin
      ctrl_m = merge({29'b0, ie_q, os_q, en_q}, bus.wdata, byte_mask);
      cnt_m  = merge(32'(cnt_q), bus.wdata, byte_mask);
      rld_m  = merge(32'(rld_q), bus.wdata, byte_mask);
      en_d   = en_q;
      os_d   = os_q;
      ie_d   = ie_q;
      cnt_d  = cnt_q;
      rld_d  = rld_q;
      expire = 1'b0;
      if (tick && en_q && !cnt_wr) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          expire = 1'b1;
          if (os_q) en_d  = 1'b0;
          else      cnt_d = rld_q;
        end
      end
      if (ctrl_wr) begin
        en_d = ctrl_m[0];
        os_d = ctrl_m[1];
        ie_d = ctrl_m[2];
      end
      if (cnt_wr) cnt_d = cnt_m[width-1:0];
      if (rld_wr) rld_d = rld_m[width-1:0];
      pend_d = (pend_q & ~(stat_wr & bus.we[0] & bus.wdata[0])) | expire;
      irq_d  = pend_q & ie_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_q   <= 1'b0;
        os_q   <= 1'b0;
        ie_q   <= 1'b0;
        pend_q <= 1'b0;
        irq_q  <= 1'b0;
        cnt_q  <= '0;
        rld_q  <= '0;
      end else begin
        en_q   <= en_d;
        os_q   <= os_d;
        ie_q   <= ie_d;
        pend_q <= pend_d;
        irq_q  <= irq_d;
        cnt_q  <= cnt_d;
        rld_q  <= rld_d;
      end
    end

    assign irq[gi]      = irq_q;
    assign pend_vec[gi] = pend_q;
    assign rd_ctrl[gi]  = {29'b0, ie_q, os_q, en_q};
    assign rd_cnt[gi]   = 32'(cnt_q);
    assign rd_rld[gi]   = 32'(rld_q);
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_val = '0;
    if (is_ch) begin
      for (int i = 0; i < channels; i++) begin
        if (sel_ch == 3'(i)) begin
          case (sel_reg)
            2'd0:    rd_val = rd_ctrl[i];
            2'd1:    rd_val = rd_cnt[i];
            2'd2:    rd_val = rd_rld[i];
            default: rd_val = {31'b0, pend_vec[i]};
          endcase
        end
      end
    end else if (off == IDX_PRE) begin
      rd_val = 32'(prescale_q);
    end else if (off == IDX_PEND) begin
      rd_val = 32'(pend_vec);
    end
  end

  // Zero on no access so the overlay can OR-combine peripherals.
  assign bus.ready = acc;
  assign bus.rdata = acc ? rd_val : 32'h0;

endmodule

// File: tb/tb_boa_peri_timer.sv
// Directed bench for boa_peri_timer: a default build plus a narrow 2-channel,
// 16-bit build for truncation and decode checks.
module tb_boa_peri_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq0;
  logic [1:0] irq1;
  int n_assert = 0;
  int n_fail   = 0;

  boa_mem_bus #(.alen(12)) bus0 ();
  boa_mem_bus #(.alen(12)) bus1 ();

  boa_peri_timer dut0 (.clk(clk), .rst(rst), .bus(bus0), .irq(irq0));
  boa_peri_timer #(.channels(2), .width(16), .pre_width(4))
    dut1 (.clk(clk), .rst(rst), .bus(bus1), .irq(irq1));

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%08h expected 'h%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus0.re = 1'b0; bus0.we = 4'h0; bus0.addr = 12'h0; bus0.wdata = 32'h0;
    bus1.re = 1'b0; bus1.we = 4'h0; bus1.addr = 12'h0; bus1.wdata = 32'h0;
  endtask

  // One bus cycle, driven at a negedge and sampled 1 time unit later.
  task automatic cyc(input int d, input logic r, input logic [3:0] w,
                     input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus_idle();
    if (d == 0) begin
      bus0.re = r; bus0.we = w; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.re = r; bus1.we = w; bus1.addr = a; bus1.wdata = wd;
    end
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd);
    cyc(0, 1'b0, 4'hF, a, wd);
  endtask

  task automatic rd(input int d, input logic [11:0] a, input logic [31:0] exp, input string tag);
    cyc(d, 1'b1, 4'h0, a, 32'h0);
    check(tag, (d == 0) ? bus0.rdata : bus1.rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b0, 4'h0, 12'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bus_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_irq0", 32'(irq0), 32'h0);
    check("reset_ready_idle", 32'(bus0.ready), 32'h0);
    rst = 1'b1;
    rd(0, 12'h3F0, 32'h0, "reset_prescale");
    rd(0, 12'h3F4, 32'h0, "reset_pending");
    rd(0, 12'h300, 32'h0, "reset_ctrl0");

    // 1. periodic mode, period RELOAD+1
    do_reset();
    wr(12'h308, 32'd4);
    wr(12'h304, 32'd4);
    wr(12'h300, 32'h5);
    rd(0, 12'h304, 32'd4, "per_cnt_4");
    rd(0, 12'h304, 32'd3, "per_cnt_3");
    rd(0, 12'h304, 32'd2, "per_cnt_2");
    rd(0, 12'h304, 32'd1, "per_cnt_1");
    rd(0, 12'h304, 32'd0, "per_cnt_0");
    rd(0, 12'h304, 32'd4, "per_cnt_reload");
    check("per_irq_lag", 32'(irq0[0]), 32'h0);
    rd(0, 12'h30C, 32'h1, "per_pending_set");
    check("per_irq_rise", 32'(irq0[0]), 32'h1);
    wr(12'h30C, 32'h1);
    rd(0, 12'h30C, 32'h0, "per_w1c");
    check("per_irq_hold", 32'(irq0[0]), 32'h1);
    rd(0, 12'h30C, 32'h0, "per_pend_low1");
    check("per_irq_fall", 32'(irq0[0]), 32'h0);
    rd(0, 12'h30C, 32'h1, "per_pending_again");
    check("per_irq_lag2", 32'(irq0[0]), 32'h0);
    rd(0, 12'h30C, 32'h1, "per_pending_stay");
    check("per_irq_rise2", 32'(irq0[0]), 32'h1);

    // 2. one-shot on channel 1
    do_reset();
    wr(12'h314, 32'd2);
    wr(12'h310, 32'h3);
    rd(0, 12'h314, 32'd2, "os_cnt_2");
    rd(0, 12'h314, 32'd1, "os_cnt_1");
    rd(0, 12'h314, 32'd0, "os_cnt_0");
    rd(0, 12'h31C, 32'h1, "os_pending");
    rd(0, 12'h310, 32'h2, "os_en_cleared");
    rd(0, 12'h314, 32'd0, "os_cnt_hold");
    rd(0, 12'h3F4, 32'h2, "os_pending_map");
    check("os_irq_masked", 32'(irq0), 32'h0);

    // 3. prescaler
    do_reset();
    wr(12'h3F0, 32'd3);
    wr(12'h304, 32'd1);
    wr(12'h308, 32'd1);
    wr(12'h300, 32'h1);
    idle(4);
    rd(0, 12'h30C, 32'h0, "pre_before_exp");
    rd(0, 12'h30C, 32'h1, "pre_exp1");
    wr(12'h30C, 32'h1);
    idle(5);
    rd(0, 12'h30C, 32'h0, "pre_before_exp2");
    rd(0, 12'h30C, 32'h1, "pre_exp2_8cyc");
    wr(12'h3F0, 32'd2);
    rd(0, 12'h304, 32'd1, "pre_restart_a");
    rd(0, 12'h304, 32'd1, "pre_restart_b");
    rd(0, 12'h304, 32'd1, "pre_restart_c");
    rd(0, 12'h304, 32'd0, "pre_restart_tick");

    // 4. collisions
    do_reset();
    wr(12'h308, 32'd2);
    wr(12'h304, 32'd2);
    wr(12'h300, 32'h1);
    idle(2);
    wr(12'h30C, 32'h1);
    rd(0, 12'h30C, 32'h1, "col_set_wins");
    wr(12'h30C, 32'h1);
    rd(0, 12'h30C, 32'h0, "col_w1c_plain");
    wr(12'h30C, 32'h1);
    idle(1);
    wr(12'h304, 32'h10);
    rd(0, 12'h304, 32'h10, "col_cnt_write_wins");
    rd(0, 12'h30C, 32'h0, "col_no_expiry");

    // 5. bus decode and truncation
    do_reset();
    cyc(0, 1'b0, 4'b0001, 12'h308, 32'hAABBCCDD);
    rd(0, 12'h308, 32'h000000DD, "dec_byte0");
    cyc(0, 1'b0, 4'b0100, 12'h308, 32'h11223344);
    rd(0, 12'h308, 32'h002200DD, "dec_byte2");
    wr(12'h300, 32'hFFFFFFFE);
    rd(0, 12'h300, 32'h6, "dec_ctrl_bits");
    rd(0, 12'h3F8, 32'h0, "dec_unmapped");
    check("dec_unmapped_ready", 32'(bus0.ready), 32'h1);
    rd(0, 12'h400, 32'h0, "dec_miss_rdata");
    check("dec_miss_ready", 32'(bus0.ready), 32'h0);
    wr(12'h404, 32'd5);
    rd(0, 12'h304, 32'h0, "dec_miss_write");
    cyc(1, 1'b0, 4'hF, 12'h304, 32'hFFFF1234);
    rd(1, 12'h304, 32'h1234, "w16_count_trunc");
    cyc(1, 1'b0, 4'hF, 12'h320, 32'h77);
    rd(1, 12'h320, 32'h0, "ch2_absent");
    cyc(1, 1'b0, 4'hF, 12'h3F0, 32'hFFFF);
    rd(1, 12'h3F0, 32'hF, "pre4_trunc");

    // 6. asynchronous reset mid-count
    do_reset();
    wr(12'h308, 32'd3);
    wr(12'h304, 32'd3);
    wr(12'h300, 32'h5);
    idle(5);
    rd(0, 12'h304, 32'd2, "ar_running_cnt");
    check("ar_irq_high", 32'(irq0), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("ar_irq_cleared", 32'(irq0), 32'h0);
    check("ar_cnt_cleared", bus0.rdata, 32'h0);
    bus0.addr = 12'h30C;
    #1;
    check("ar_pend_cleared", bus0.rdata, 32'h0);
    bus0.addr = 12'h308;
    #1;
    check("ar_reload_cleared", bus0.rdata, 32'h0);
    rst = 1'b1;
    wr(12'h304, 32'd5);
    idle(3);
    rd(0, 12'h304, 32'd5, "ar_no_count");
    rd(0, 12'h300, 32'h0, "ar_disabled");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/boa_peri_timer.md
Name: boa_peri_timer

Overview:
- Multi-channel programmable timer peripheral on the 12-bit peripheral sub-bus (boa_mem_bus, alen=12), sitting behind the memory overlay next to UART, PMU and GPIO.
- N independent down-counters share one prescaler.
- Each channel supports periodic reload or one-shot mode.
- Each channel has a sticky pending flag and a maskable interrupt line that the SoC top routes into CPU irq[31:18].

Parameters:
- addr, 'h300, peripheral base; block claims the 256-byte window where bus.addr[11:8] == addr[11:8].
- channels, 4, number of timer channels, legal range 1..8.
- width, 32, counter/reload width in bits, legal range 8..32.
- pre_width, 16, prescaler width in bits, legal range 1..16.

Ports:
- clk, in, 1, CPU clock; the only clock.
- rst, in, 1, asynchronous active-low reset.
- bus, boa_mem_bus.MEM, alen=12, register access: re, we[3:0], addr, wdata, rdata, ready.
- irq, out, channels, per-channel interrupt = pending & irq_en, registered.

Behaviour:

Register map (offset = bus.addr[7:0], word aligned; ch = offset[6:4] for offsets below 'h80):
- ch*16+0 CTRL: bit0 en, bit1 oneshot, bit2 irq_en; other bits read 0.
- ch*16+4 COUNT: current count, read/write.
- ch*16+8 RELOAD: reload value, read/write.
- ch*16+12 STATUS: bit0 pending; write-1-to-clear.
- 'hF0 PRESCALE: prescaler terminal value, read/write.
- 'hF4 PENDING: read-only bitmap of all pending flags.
- Offsets for channels >= `channels` and unmapped offsets read 0; writes to them are ignored.

Bus:
- ready is asserted combinationally in any cycle with re or any we bit set and an address hit.
- rdata is combinational from registers in the same cycle.
- On no hit, ready=0 and rdata=0, so the overlay can OR-combine.
- Byte lanes follow we[3:0]. Bits above width (or pre_width) are truncated on write and read back as 0.

Prescaler:
- pre_cnt counts up each clk.
- When pre_cnt == PRESCALE: tick=1 for that cycle and pre_cnt returns to 0.
- PRESCALE=0 gives a tick every cycle.
- A write to PRESCALE also clears pre_cnt to 0 in that cycle; no tick occurs that cycle.

Per channel, on a tick cycle with en=1:
- COUNT != 0: COUNT <= COUNT-1.
- COUNT == 0 and oneshot=0: pending <= 1, COUNT <= RELOAD. The period is therefore RELOAD+1 ticks.
- COUNT == 0 and oneshot=1: pending <= 1, en <= 0, COUNT holds at 0.
- Channels with en=0 are frozen; pending holds.

Simultaneous events:
- Bus write to COUNT in a tick cycle: the written value wins, with no decrement and no expiry that cycle.
- STATUS W1C in the same cycle as a new expiry: set wins, pending stays 1.
- CTRL write setting en=1 in a tick cycle: counting starts on the next tick.

Interrupts:
- irq[i] is a registered (pending[i] & irq_en[i]), valid 1 cycle after pending or irq_en changes.
- Clearing irq_en masks irq without clearing pending.

Reset (rst low, asynchronous, any time including mid-count):
- All CTRL, COUNT, RELOAD, pending, PRESCALE, pre_cnt and irq = 0.
- bus.ready and bus.rdata are combinational, so they are 0 absent an access.
- Released state: all channels disabled, prescaler ticking every cycle.

Test Plan:
1. Periodic mode: PRESCALE=0, ch0 RELOAD=4, COUNT=4, CTRL=en|irq_en.
   - pending/irq pulse sets every 5 cycles.
   - irq rises 1 cycle after pending.
   - COUNT sequence 4,3,2,1,0,4.
2. One-shot mode: ch1 COUNT=2, CTRL=en|oneshot.
   - After 3 ticks: pending=1, CTRL.en reads 0, COUNT stays 0.
   - PENDING reads 'b10.
3. Prescaler: PRESCALE=3, ch0 COUNT=1, RELOAD=1, en.
   - Expiry every 8 clk cycles.
   - Writing PRESCALE mid-count restarts pre_cnt; the next tick arrives exactly PRESCALE+1 cycles after the write.
4. Collisions:
   - W1C STATUS in the same cycle ch0 expires -> pending remains 1.
   - Write COUNT='h10 in a tick cycle -> COUNT reads 'h10 next cycle, no pending set.
5. Bus decode:
   - Byte write we='b0001 of 'hAABBCCDD to RELOAD (reset 0) -> reads 'h000000DD.
   - width=16 build: COUNT write 'hFFFF1234 reads 'h1234.
   - channels=2: offset 'h20 reads 0.
   - Address 'h400 -> ready=0, rdata=0.
6. Async reset mid-operation: assert rst low between clk edges with counters running and irq high.
   - irq, pending and COUNT go 0 immediately without a clock edge.
   - After release, no channel counts until re-enabled.
